// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU function codes,
// flag bit positions and the issue FSM state encoding.
package alu_pkg;

  // ALU_module function codes
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0001;
  localparam logic [3:0] MUL  = 4'b0010;
  localparam logic [3:0] DIV  = 4'b0011;
  localparam logic [3:0] AND  = 4'b0100;
  localparam logic [3:0] OR   = 4'b0101;
  localparam logic [3:0] NAND = 4'b0110;
  localparam logic [3:0] NOR  = 4'b0111;
  localparam logic [3:0] XOR  = 4'b1000;
  localparam logic [3:0] XNOR = 4'b1001;
  localparam logic [3:0] CMPEQ = 4'b1010;
  localparam logic [3:0] CMPGT = 4'b1011;
  localparam logic [3:0] CMPLT = 4'b1100;
  localparam logic [3:0] SHR  = 4'b1101;
  localparam logic [3:0] SHL  = 4'b1110;

  // Bit positions inside the 4-bit class flag vector
  localparam int ARITH = 3;
  localparam int LOGIC = 2;
  localparam int CMP   = 1;
  localparam int SHIFT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } seq_state_e;

  // A divide whose divisor is zero
  function automatic logic is_div0(input logic [3:0] fun, input logic b_zero);
    return (fun == DIV) && b_zero;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle of the ALU command sequencer.
// RSP_ERR exists only when ALU_SEQ_DIV0_CHK_EN is defined.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) ();
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;
  logic [3:0]       CMD_FUN;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [WIDTH-1:0] RSP_DATA;
  logic [3:0]       RSP_FLAGS;
  logic [TAG_W-1:0] RSP_TAG;
`ifdef ALU_SEQ_DIV0_CHK_EN
  logic             RSP_ERR;
`endif

  // Command producer / response consumer side
  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_TAG
`ifdef ALU_SEQ_DIV0_CHK_EN
    , input RSP_ERR
`endif
  );

  // Sequencer side
  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_TAG
`ifdef ALU_SEQ_DIV0_CHK_EN
    , output RSP_ERR
`endif
  );
endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO. Head entry is visible on rdata while not empty.
// ready is a registered "not full" that stays low while reset is asserted.
module alu_cmd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] lvl_r;
  logic [LVL_W-1:0] lvl_nxt_s;
  logic             ready_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (lvl_r == LVL_W'(DEPTH));
  assign empty     = (lvl_r == LVL_W'(0));
  assign do_push_s = push && !full_s;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = lvl_r;
  assign ready     = ready_r;

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    lvl_nxt_s = lvl_r;
    case ({do_push_s, do_pop_s})
      2'b10:   lvl_nxt_s = lvl_r + LVL_W'(1);
      2'b01:   lvl_nxt_s = lvl_r - LVL_W'(1);
      default: lvl_nxt_s = lvl_r;
    endcase
  end

  // Pointers, occupancy and registered ready flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      lvl_r    <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      lvl_r   <= lvl_nxt_s;
      ready_r <= (lvl_nxt_s != LVL_W'(DEPTH));
    end
  end

  // Entry storage, cleared on reset so stale commands never reappear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of ALU_module: buffers commands, issues one at a time,
// waits ALU_LAT edges, then holds the tagged result until it is taken.
// Optional macro ALU_SEQ_DIV0_CHK_EN: divide-by-zero is answered locally
// with an error response and an RSP_ERR output.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  alu_cmd_sequencer_if.slave     bus,
  output logic [WIDTH-1:0]       ALU_A,
  output logic [WIDTH-1:0]       ALU_B,
  output logic [3:0]             ALU_FUN,
  input  logic [WIDTH-1:0]       ALU_OUT,
  input  logic [3:0]             ALU_FLAGS,
  output logic [$clog2(DEPTH):0] FIFO_LVL
);
  localparam int ENTRY_W = 2*WIDTH + 4 + TAG_W;
  localparam int CNT_W   = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  seq_state_e         state_r, state_nxt_s;
  logic [ENTRY_W-1:0] head_s;
  logic [WIDTH-1:0]   head_a_s, head_b_s;
  logic [3:0]         head_fun_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic               head_div0_s;
  logic               fifo_empty_s, fifo_ready_s;
  logic               push_s, pop_s, issue_s, capture_s, err_load_s, rsp_clear_s;
  logic               rsp_fire_s;

  logic [WIDTH-1:0]   alu_a_r, alu_b_r, rsp_data_r;
  logic [3:0]         alu_fun_r, rsp_flags_r;
  logic [TAG_W-1:0]   tag_r, inflight_tag_r, rsp_tag_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               rsp_valid_r, rsp_err_r;

  assign push_s     = bus.CMD_VALID && fifo_ready_s;
  assign rsp_fire_s = rsp_valid_r && bus.RSP_READY;

  alu_cmd_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_s),
    .wdata ({tag_r, bus.CMD_FUN, bus.CMD_B, bus.CMD_A}),
    .pop   (pop_s),
    .rdata (head_s),
    .empty (fifo_empty_s),
    .ready (fifo_ready_s),
    .level (FIFO_LVL)
  );

  assign head_a_s   = head_s[WIDTH-1:0];
  assign head_b_s   = head_s[2*WIDTH-1:WIDTH];
  assign head_fun_s = head_s[2*WIDTH+3:2*WIDTH];
  assign head_tag_s = head_s[ENTRY_W-1:2*WIDTH+4];
`ifdef ALU_SEQ_DIV0_CHK_EN
  assign head_div0_s = is_div0(head_fun_s, (head_b_s == '0));
`else
  assign head_div0_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) state_nxt_s = head_div0_s ? RESP : WAIT;
        else               state_nxt_s = IDLE;
      end
      WAIT: begin
        if (cnt_r == CNT_W'(0)) state_nxt_s = RESP;
        else                    state_nxt_s = WAIT;
      end
      RESP: begin
        if (rsp_fire_s) begin
          if (!fifo_empty_s) state_nxt_s = head_div0_s ? RESP : WAIT;
          else               state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM control strobes for the datapath registers
  always_comb begin
    pop_s       = 1'b0;
    issue_s     = 1'b0;
    err_load_s  = 1'b0;
    capture_s   = 1'b0;
    rsp_clear_s = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s      = !fifo_empty_s;
        issue_s    = !fifo_empty_s && !head_div0_s;
        err_load_s = !fifo_empty_s && head_div0_s;
      end
      WAIT: begin
        capture_s = (cnt_r == CNT_W'(0));
      end
      RESP: begin
        rsp_clear_s = rsp_fire_s;
        pop_s       = rsp_fire_s && !fifo_empty_s;
        issue_s     = rsp_fire_s && !fifo_empty_s && !head_div0_s;
        err_load_s  = rsp_fire_s && !fifo_empty_s && head_div0_s;
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // ALU operand registers; they keep the last issued command between ops
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      alu_fun_r      <= 4'b0000;
      inflight_tag_r <= '0;
    end else if (issue_s) begin
      alu_a_r        <= head_a_s;
      alu_b_r        <= head_b_s;
      alu_fun_r      <= head_fun_s;
      inflight_tag_r <= head_tag_s;
    end
  end

  // ALU latency counter, loaded on issue and run down while waiting
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= '0;
    end else if (issue_s) begin
      cnt_r <= CNT_W'(ALU_LAT);
    end else if ((state_r == WAIT) && (cnt_r != CNT_W'(0))) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Held response: captured from the ALU, or synthesized for divide-by-zero
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_flags_r <= 4'b0000;
      rsp_tag_r   <= '0;
      rsp_err_r   <= 1'b0;
    end else if (capture_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= ALU_OUT;
      rsp_flags_r <= ALU_FLAGS;
      rsp_tag_r   <= inflight_tag_r;
      rsp_err_r   <= 1'b0;
    end else if (err_load_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= {WIDTH{1'b1}};
      rsp_flags_r <= 4'b1000;
      rsp_tag_r   <= head_tag_s;
      rsp_err_r   <= 1'b1;
    end else if (rsp_clear_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Sequence tag, advanced for every accepted command
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        tag_r <= '0;
    else if (push_s) tag_r <= tag_r + TAG_W'(1);
  end

  assign bus.CMD_READY = fifo_ready_s;
  assign bus.RSP_VALID = rsp_valid_r;
  assign bus.RSP_DATA  = rsp_data_r;
  assign bus.RSP_FLAGS = rsp_flags_r;
  assign bus.RSP_TAG   = rsp_tag_r;
`ifdef ALU_SEQ_DIV0_CHK_EN
  assign bus.RSP_ERR   = rsp_err_r;
`else
  logic unused_err_s;
  assign unused_err_s = rsp_err_r;
`endif
  assign ALU_A   = alu_a_r;
  assign ALU_B   = alu_b_r;
  assign ALU_FUN = alu_fun_r;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and a
// response scoreboard. Covers ALU_SEQ_DIV0_CHK_EN when that macro is defined.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    logic [3:0]  t;
    logic        e;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic [3:0]  ALU_FUN, ALU_FLAGS;
  logic [2:0]  FIFO_LVL;

  rsp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  tag_ctr = 4'd0;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(1), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_FUN   (ALU_FUN),
    .ALU_OUT   (ALU_OUT),
    .ALU_FLAGS (ALU_FLAGS),
    .FIFO_LVL  (FIFO_LVL)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU_module: {result, flags}
  function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f);
    logic [15:0] r;
    logic [3:0]  fl;
    r = 16'd0;
    fl = 4'b0000;
    case (f)
      4'd0:  begin r = a + b; fl = 4'b1000; end
      4'd1:  begin r = a - b; fl = 4'b1000; end
      4'd2:  begin r = a * b; fl = 4'b1000; end
      4'd3:  begin r = (b == 16'd0) ? 16'd0 : a / b; fl = 4'b1000; end
      4'd4:  begin r = a & b; fl = 4'b0100; end
      4'd5:  begin r = a | b; fl = 4'b0100; end
      4'd6:  begin r = ~(a & b); fl = 4'b0100; end
      4'd7:  begin r = ~(a | b); fl = 4'b0100; end
      4'd8:  begin r = a ^ b; fl = 4'b0100; end
      4'd9:  begin r = ~(a ^ b); fl = 4'b0100; end
      4'd10: begin r = (a == b) ? 16'd1 : 16'd0; fl = 4'b0010; end
      4'd11: begin r = (a > b) ? 16'd2 : 16'd0; fl = 4'b0010; end
      4'd12: begin r = (a < b) ? 16'd3 : 16'd0; fl = 4'b0010; end
      4'd13: begin r = a >> 1; fl = 4'b0001; end
      4'd14: begin r = a << 1; fl = 4'b0001; end
      default: begin r = 16'd0; fl = 4'b0000; end
    endcase
    return {r, fl};
  endfunction

  // Registered ALU with one edge of latency
  always @(posedge CLK) {ALU_OUT, ALU_FLAGS} <= alu_f(ALU_A, ALU_B, ALU_FUN);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response taken must be the oldest expected one
  always @(negedge CLK) begin
    rsp_t e;
    if (RST && bus.RSP_VALID && bus.RSP_READY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, bus.RSP_VALID}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {16'd0, bus.RSP_DATA}, {16'd0, e.d});
        chk("rsp_flags", {28'd0, bus.RSP_FLAGS}, {28'd0, e.f});
        chk("rsp_tag", {28'd0, bus.RSP_TAG}, {28'd0, e.t});
`ifdef ALU_SEQ_DIV0_CHK_EN
        chk("rsp_err", {31'd0, bus.RSP_ERR}, {31'd0, e.e});
`endif
      end
    end
  end

  // Offer one command, wait for acceptance, record its expected response
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int   n;
    rsp_t e;
    logic [19:0] r;
    n = 0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_A = a;
    bus.CMD_B = b;
    bus.CMD_FUN = f;
    @(negedge CLK);
    while (!bus.CMD_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.CMD_READY) begin
      chk("push_timeout", {31'd0, bus.CMD_READY}, 32'd1);
    end else begin
      r = alu_f(a, b, f);
      e.d = r[19:4];
      e.f = r[3:0];
      e.t = tag_ctr;
      e.e = 1'b0;
`ifdef ALU_SEQ_DIV0_CHK_EN
      if (f == DIV && b == 16'd0) begin
        e.d = 16'hFFFF;
        e.f = 4'b1000;
        e.e = 1'b1;
      end
`endif
      exp_q.push_back(e);
      tag_ctr = tag_ctr + 4'd1;
    end
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    exp_q.delete();
    tag_ctr = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, bus.CMD_READY}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.RSP_VALID}, 32'd0);
    chk({tag, "_rsp_data"}, {16'd0, bus.RSP_DATA}, 32'd0);
    chk({tag, "_rsp_flags"}, {28'd0, bus.RSP_FLAGS}, 32'd0);
    chk({tag, "_rsp_tag"}, {28'd0, bus.RSP_TAG}, 32'd0);
    chk({tag, "_alu_a"}, {16'd0, ALU_A}, 32'd0);
    chk({tag, "_alu_b"}, {16'd0, ALU_B}, 32'd0);
    chk({tag, "_alu_fun"}, {28'd0, ALU_FUN}, 32'd0);
    chk({tag, "_fifo_lvl"}, {29'd0, FIFO_LVL}, 32'd0);
  endtask

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_A = 16'd0;
    bus.CMD_B = 16'd0;
    bus.CMD_FUN = 4'd0;
    bus.RSP_READY = 1'b1;
    RST = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("ready_after_release", {31'd0, bus.CMD_READY}, 32'd1);

    // Single ADD: issue one edge after push, response three edges after push
    push(16'd10, 16'd20, ADD);
    chk("t1_lvl_push", {29'd0, FIFO_LVL}, 32'd1);
    chk("t1_valid_e0", {31'd0, bus.RSP_VALID}, 32'd0);
    @(posedge CLK); #1;
    chk("t1_alu_a", {16'd0, ALU_A}, 32'd10);
    chk("t1_alu_b", {16'd0, ALU_B}, 32'd20);
    chk("t1_alu_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("t1_lvl_issue", {29'd0, FIFO_LVL}, 32'd0);
    chk("t1_valid_e1", {31'd0, bus.RSP_VALID}, 32'd0);
    @(posedge CLK); #1;
    chk("t1_valid_e2", {31'd0, bus.RSP_VALID}, 32'd0);
    @(posedge CLK); #1;
    chk("t1_valid_e3", {31'd0, bus.RSP_VALID}, 32'd1);
    chk("t1_data", {16'd0, bus.RSP_DATA}, 32'd30);
    chk("t1_flags", {28'd0, bus.RSP_FLAGS}, 32'h8);
    chk("t1_tag", {28'd0, bus.RSP_TAG}, 32'd0);
    wait_drain();

    // Back-to-back MUL / OR / SHR in order
    push(16'd20, 16'd10, MUL);
    push(16'd20, 16'd10, OR);
    push(16'd20, 16'd0, SHR);
    wait_drain();

    // Backpressure: five accepted, sixth refused, held response stable
    do_reset();
    bus.RSP_READY = 1'b0;
    for (int i = 0; i < 5; i++) push(16'(i + 3), 16'(2 * i + 1), ADD);
    @(posedge CLK); #1;
    bus.CMD_VALID = 1'b1;
    bus.CMD_A = 16'd99;
    bus.CMD_B = 16'd1;
    bus.CMD_FUN = SUB;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_cmd_ready", {31'd0, bus.CMD_READY}, 32'd0);
      chk("bp_lvl", {29'd0, FIFO_LVL}, 32'd4);
      chk("bp_valid", {31'd0, bus.RSP_VALID}, 32'd1);
      chk("bp_data_held", {16'd0, bus.RSP_DATA}, {16'd0, exp_q[0].d});
      chk("bp_tag_held", {28'd0, bus.RSP_TAG}, {28'd0, exp_q[0].t});
    end
    @(posedge CLK); #1;
    bus.CMD_VALID = 1'b0;
    bus.RSP_READY = 1'b1;
    wait_drain();
    chk("bp_lvl_empty", {29'd0, FIFO_LVL}, 32'd0);

    // Seventeen commands: tag wraps to 0 on the last
    do_reset();
    for (int i = 0; i < 17; i++)
      push(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    wait_drain();

    // Random commands under random response backpressure
    fork
      begin
        for (int i = 0; i < 30; i++)
          push(16'($urandom), 16'($urandom_range(0, 300)), 4'($urandom_range(0, 15)));
      end
      begin
        repeat (150) begin
          @(posedge CLK); #1;
          bus.RSP_READY = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.RSP_READY = 1'b1;
    wait_drain();

    // Reset while an operation waits on the ALU
    push(16'h1234, 16'h0056, XOR);
    push(16'h0F0F, 16'h00FF, AND);
    chk("rst_mid_lvl", {29'd0, FIFO_LVL}, 32'd1);
    chk("rst_mid_alu_a", {16'd0, ALU_A}, 32'h1234);
    RST = 1'b0;
    exp_q.delete();
    tag_ctr = 4'd0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      chk("post_rst_valid", {31'd0, bus.RSP_VALID}, 32'd0);
      chk("post_rst_lvl", {29'd0, FIFO_LVL}, 32'd0);
    end

`ifdef ALU_SEQ_DIV0_CHK_EN
    // Divide-by-zero answered locally, ALU inputs untouched
    push(16'd7, 16'd3, SUB);
    wait_drain();
    push(16'd20, 16'd0, DIV);
    repeat (3) @(posedge CLK);
    #1;
    chk("div0_alu_fun", {28'd0, ALU_FUN}, {28'd0, SUB});
    chk("div0_alu_b", {16'd0, ALU_B}, 32'd3);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for ALU_module. It accepts ALU commands (A, B, ALU_FUN) over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the registered ALU, waits out the ALU latency, then captures ALU_OUT plus the four class flags into a held response with a sequence tag. Responses leave in command order through a second valid/ready interface.

Parameters:
WIDTH, 16, operand/result width; must match ALU_module.
DEPTH, 4, command FIFO entries; power of two, >= 2.
ALU_LAT, 1, rising edges from ALU inputs changing to ALU_OUT valid.
TAG_W, 4, width of the sequence tag counter.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  reset, asynchronous, active-low.
CMD_VALID  in  1  command present.
CMD_READY  out  1  command accepted when high with CMD_VALID.
CMD_A  in  WIDTH  operand A.
CMD_B  in  WIDTH  operand B.
CMD_FUN  in  4  ALU function code, 0000..1110 as defined for ALU_module.
ALU_A  out  WIDTH  to ALU_module A.
ALU_B  out  WIDTH  to ALU_module B.
ALU_FUN  out  4  to ALU_module ALU_FUN.
ALU_OUT  in  WIDTH  from ALU_module ALU_OUT.
ALU_FLAGS  in  4  {Arith_flag, Logic_flag, CMP_flag, Shift_flag} from ALU_module.
RSP_VALID  out  1  response held.
RSP_READY  in  1  consumer takes response.
RSP_DATA  out  WIDTH  captured result.
RSP_FLAGS  out  4  captured flags, same order as ALU_FLAGS.
RSP_TAG  out  TAG_W  sequence number of the command.
FIFO_LVL  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST low, async): FIFO empty, FSM in IDLE. CMD_READY=0 while RST is low, 1 after release. All ALU_*, RSP_* outputs and the tag counter are 0. FIFO_LVL=0.
- CMD_READY = !full, from registered state. A pop in the same cycle does not admit a push when full.
- Push and pop in the same cycle leave FIFO_LVL unchanged.
- Each accepted command is assigned the tag counter value; the counter increments mod 2^TAG_W.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the ALU_A/ALU_B/ALU_FUN registers and go to WAIT with cnt=ALU_LAT.
  - WAIT: cnt decrements each edge. At the edge where cnt==0, capture ALU_OUT/ALU_FLAGS into RSP_DATA/RSP_FLAGS, set RSP_VALID=1, go to RESP. The capture happens at the (ALU_LAT+1)th edge after the issue edge.
  - RESP: RSP_* are held stable while RSP_READY=0. On RSP_VALID&RSP_READY, RSP_VALID drops. If the FIFO is non-empty, pop and issue in the same edge and go to WAIT; otherwise go to IDLE.
- ALU_* keep their last issued values between operations (no return to zero).
- One operation is outstanding at a time.
- Latency, empty FIFO, RSP_READY=1, ALU_LAT=1: push at edge k, issue at k+1, capture at k+3. Steady-state throughput is one response per ALU_LAT+2 cycles.
- CMD_FUN=1111 is forwarded unchanged; the captured ALU output is returned as-is.
- Reset mid-operation: the in-flight command, held response and FIFO contents are discarded, and the ALU result is ignored.
- Tag wraps from 2^TAG_W-1 to 0 without a stall.

Optional Feature:
- Macro: ALU_SEQ_DIV0_CHK_EN.
- Defined: a command with CMD_FUN=0011 and CMD_B=0 is not issued to the ALU. Instead, next edge RSP_VALID=1 with RSP_DATA={WIDTH{1'b1}}, RSP_FLAGS=4'b1000 and an extra output port RSP_ERR=1. RSP_ERR=0 for all other responses.
- Undefined: no RSP_ERR port; divide-by-zero is issued like any other command.

Decomposition:
- Shared package alu_pkg:
  - ALU function code localparams (ADD=4'b0000 .. SHL=4'b1110).
  - Flag bit index constants (ARITH=3, LOGIC=2, CMP=1, SHIFT=0).
  - FSM state encoding (IDLE, WAIT, RESP).
- One sub-module: alu_cmd_fifo. Synchronous FIFO, DEPTH x (2*WIDTH+4+TAG_W) bits, with full/empty/level outputs and the same CLK/RST.

Test Plan:
- Push A=10,B=20,FUN=0000 with RSP_READY=1 -> RSP_VALID 3 edges after push; RSP_DATA=30, RSP_FLAGS=4'b1000, RSP_TAG=0.
- Push FUN=0010 (20,10), FUN=0101 (20,10), FUN=1101 (20,0) back-to-back -> responses in order: 200/tag1, 30/tag2, 10/tag3; flags 1000, 0100, 0001.
- RSP_READY=0, push 6 commands -> first 5 accepted (FIFO_LVL reaches 4), CMD_READY=0 on 6th. Raise RSP_READY -> tags 0..4 in order, RSP_* stable while stalled.
- Push 17 commands with TAG_W=4 -> 17th response carries RSP_TAG=0.
- Assert RST low during WAIT -> all outputs 0 immediately; after release no response emerges and FIFO_LVL=0.
- With ALU_SEQ_DIV0_CHK_EN: A=20,B=0,FUN=0011 -> RSP_DATA=16'hFFFF, RSP_ERR=1, ALU_FUN unchanged from the previous op.
